// File: rtl/serial_alu_pkg.sv
// Shared opcode encodings and FSM state type for the bit-serial ALU.
package serial_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LESS = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unused encodings 101..111 behave as ADD.
  function automatic logic [2:0] fold_op(input logic [2:0] op);
    return (op > OP_LESS) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: AND/OR/ADD/SUB/LESS with carry or borrow chaining.
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       dout,
  output logic       cout
);

  always_comb begin
    dout = 1'b0;
    cout = 1'b0;
    case (fold_op(op))
      OP_AND: dout = a & b;
      OP_OR:  dout = a | b;
      OP_SUB, OP_LESS: begin
        dout = a ^ b ^ cin;
        cout = (~a & b) | (~(a ^ b) & cin);
      end
      default: begin
        dout = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: latches operands, runs the slice LSB-first
// and presents a registered result with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per clock through the slice
// DONE  | result valid, done pulse; start here re-enters RUN directly
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, shadow_q, result_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, zero_q, busy_q, done_q;

  logic             slice_dout, slice_cout;
  logic [WIDTH-1:0] shadow_d, result_d;
  logic             cout_d;

  serial_alu_slice u_slice (
    .op   (op_q),
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .dout (slice_dout),
    .cout (slice_cout)
  );

  // Values used on the last RUN cycle, when the MSB comes out of the slice.
  always_comb begin
    shadow_d = {slice_dout, shadow_q[WIDTH-1:1]};
    result_d = shadow_d;
    cout_d   = 1'b0;
    if (op_q == OP_LESS) begin
      result_d = {{(WIDTH-1){1'b0}}, slice_cout};
    end else if (op_q == OP_ADD || op_q == OP_SUB) begin
      cout_d = slice_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            op_q    <= fold_op(op);
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= slice_cout;
          shadow_q <= shadow_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= (result_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] r, output logic c);
    logic [W:0] s;
    case (o)
      3'd0: begin r = x & y; c = 1'b0; end
      3'd1: begin r = x | y; c = 1'b0; end
      3'd3: begin r = x - y; c = (x < y); end
      3'd4: begin r = (x < y) ? W'(1) : W'(0); c = 1'b0; end
      default: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
      end
    endcase
  endfunction

  // Pulses start from the current cycle and waits (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, y,
                        output logic [W-1:0] r, output logic c, z,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat = -1; bcnt = 0; r = 'x; c = 1'bx; z = 1'bx;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k; r = result; c = cout; z = zero;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, cout, zero, result} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00})
      $display("FAIL reset_state: got busy=%b done=%b cout=%b zero=%b result=%h want 0 0 0 1 00",
               busy, done, cout, zero, result);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]   t_op [10] = '{3'd2, 3'd2, 3'd7, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1};
    logic [W-1:0] t_a  [10] = '{8'h5A, 8'hFF, 8'h01, 8'h10, 8'h20, 8'h03, 8'h07, 8'h80, 8'hF0, 8'hF0};
    logic [W-1:0] t_b  [10] = '{8'h3C, 8'h01, 8'h02, 8'h20, 8'h10, 8'h07, 8'h03, 8'h80, 8'h3C, 8'h3C};
    logic [W-1:0] t_r  [10] = '{8'h96, 8'h00, 8'h03, 8'hF0, 8'h10, 8'h01, 8'h00, 8'h00, 8'h30, 8'hFC};
    logic         t_c  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] r; logic c, z; int lat, bcnt;
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], r, c, z, lat, bcnt);
      n_checks++;
      if (r !== t_r[i] || c !== t_c[i] || z !== (t_r[i] == 8'h00))
        $display("FAIL directed_%0d: got result=%h cout=%b zero=%b want %h %b %b",
                 i, r, c, z, t_r[i], t_c[i], t_r[i] == 8'h00);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (lat !== W || bcnt !== W)
          $display("FAIL timing: got done_after=%0d busy_cycles=%0d want %0d %0d", lat, bcnt, W, W);
        else n_pass++;
      end
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] r; logic c, z; int lat, bcnt;
    bit held_ok = 1'b1;
    run_op(3'd2, 8'h11, 8'h22, r, c, z, lat, bcnt);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; a = 8'h50; b = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin lat = k; break; end
      if (result !== 8'h33) held_ok = 1'b0;
      if (k == 3) begin start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h00; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!held_ok) $display("FAIL result_hold_in_run: got changed result, want 33 held");
    else n_pass++;
    n_checks++;
    if (lat !== W || result !== 8'h4B || cout !== 1'b0)
      $display("FAIL ignore_start: got done_after=%0d result=%h cout=%b want %0d 4b 0",
               lat, result, cout, W);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; logic c, z; int lat, bcnt;
    run_op(3'd0, 8'hF0, 8'h3C, r, c, z, lat, bcnt);
    run_op(3'd1, 8'h0F, 8'hA0, r, c, z, lat, bcnt);
    n_checks++;
    if (lat !== W || bcnt !== W || r !== 8'hAF)
      $display("FAIL back_to_back: got done_after=%0d busy_cycles=%0d result=%h want %0d %0d af",
               lat, bcnt, r, W, W);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r; logic c, z; int lat, bcnt;
    bit saw = 1'b0;
    start = 1'b1; op = 3'd2; a = 8'h5A; b = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy, done, cout, zero, result} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00})
      $display("FAIL reset_mid_run: got busy=%b done=%b cout=%b zero=%b result=%h want 0 0 0 1 00",
               busy, done, cout, zero, result);
    else n_pass++;
    repeat (12) begin
      if (done || busy) saw = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (saw) $display("FAIL no_done_after_reset: got activity=1 want 0");
    else n_pass++;
    run_op(3'd3, 8'h03, 8'h05, r, c, z, lat, bcnt);
    n_checks++;
    if (lat !== W || r !== 8'hFE || c !== 1'b1)
      $display("FAIL after_reset_op: got done_after=%0d result=%h cout=%b want %0d fe 1", lat, r, c, W);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] r, er, x, y; logic c, z, ec; logic [2:0] o; int lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = W'($urandom);
      if (i % 8 == 0) y = x;
      model(o, x, y, er, ec);
      run_op(o, x, y, r, c, z, lat, bcnt);
      n_checks++;
      if (lat !== W || r !== er || c !== ec || z !== (er == '0))
        $display("FAIL random_%0d op=%0d a=%h b=%h: got done_after=%0d result=%h cout=%b zero=%b want %0d %h %b %b",
                 i, o, x, y, lat, r, c, z, W, er, ec, er == '0);
      else n_pass++;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
